qcl_accum_frame_ctrl: RTL and testbench

Frame-sequenced accumulator controller. It accepts a stream of unsigned samples and sums exactly cfg_len samples per frame. It then presents the frame sum on a valid/ready output and either idles or restarts for the next frame. It sits between a sample producer (e.g. a filter or ADC pipe) and a result consumer, and owns the clearing, counting and back-pressure that a bare accumulator lacks.

---
 rtl/qcl_accum_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_qcl_accum_frame_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/qcl_accum_frame_ctrl.sv
// qcl_accum_frame_ctrl
//   Frame-sequenced accumulator. After an accepted start it sums exactly
//   len samples (len latched from cfg_len_i), presents the frame sum on a
//   valid/ready output, then idles or, in continuous mode, immediately
//   starts the next frame with the same length.
//
// Ports
//   clk_i, reset_ni    : clock (rising edge), asynchronous active-low reset
//   cfg_len_i          : frame length, latched only when a start is accepted
//   start_i            : start request, honoured only in IDLE with len != 0
//   cont_i             : continuous mode, sampled on the output handshake
//   clear_i            : synchronous abort to IDLE, highest priority
//   v_i, data_i        : sample stream in, consumed when v_i & ready_o
//   ready_o            : high while accumulating
//   v_o, sum_o         : frame sum out, held stable until v_o & ready_i
//   overflow_o         : sum wrapped during the frame, qualified by v_o
//   ready_i            : consumer accepts the sum
//   busy_o             : controller is not idle
//
// qcl_add_sub
//   Unsigned adder/subtractor with carry-out (borrow-not when subtracting).
//   Only the zero-latency combinational form is implemented.
//
// Ports
//   a_i, b_i           : operands
//   s_o                : a_i + b_i (or a_i - b_i), modulo 2^width_p
//   carry_o            : carry-out of the operation

module qcl_add_sub #(
    parameter int width_p          = 16,
    parameter int latency_p        = 0,
    parameter int is_add_not_sub_p = 1,
    parameter int harden_p         = 0
) (
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic [width_p-1:0] s_o,
    output logic               carry_o
);

    logic [width_p-1:0] b_eff;
    logic               cin;
    logic [width_p:0]   full;

    // Subtraction is a + ~b + 1, so carry_o then means "no borrow".
    if (is_add_not_sub_p != 0) begin : g_add
        assign b_eff = b_i;
        assign cin   = 1'b0;
    end else begin : g_sub
        assign b_eff = ~b_i;
        assign cin   = 1'b1;
    end

    if (latency_p == 0 && harden_p == 0) begin : g_generic
        assign full = {1'b0, a_i} + {1'b0, b_eff} + (width_p+1)'(cin);
    end else begin : g_fallback
        // No pipelined or hardened adder cell exists in this library, so the
        // same combinational sum is used to keep zero-latency behaviour.
        assign full = {1'b0, a_i} + {1'b0, b_eff} + (width_p+1)'(cin);
    end

    assign s_o     = full[width_p-1:0];
    assign carry_o = full[width_p];

endmodule

module qcl_accum_frame_ctrl #(
    parameter int width_p     = 16,
    parameter int sum_width_p = 24,
    parameter int len_width_p = 8,
    parameter int harden_p    = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [len_width_p-1:0] cfg_len_i,
    input  logic                   start_i,
    input  logic                   cont_i,
    input  logic                   clear_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     data_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [sum_width_p-1:0] sum_o,
    output logic                   overflow_o,
    input  logic                   ready_i,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [sum_width_p-1:0] sum_q, sum_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;
    logic [len_width_p-1:0] len_q, len_d;
    logic                   ovf_q, ovf_d;

    logic [sum_width_p-1:0] data_ext;
    logic [sum_width_p-1:0] add_sum;
    logic                   add_carry;
    logic [len_width_p-1:0] len_last;

    always_comb begin
        data_ext              = '0;
        data_ext[width_p-1:0] = data_i;
    end

    qcl_add_sub #(
        .width_p         (sum_width_p),
        .latency_p       (0),
        .is_add_not_sub_p(1),
        .harden_p        (harden_p)
    ) u_add (
        .a_i    (sum_q),
        .b_i    (data_ext),
        .s_o    (add_sum),
        .carry_o(add_carry)
    );

    // len_q is never 0 outside IDLE, so len_q - 1 cannot underflow where it is used.
    assign len_last = len_q - len_width_p'(1);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        if (clear_i) begin
            state_d = IDLE;
            sum_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && (cfg_len_i != '0)) begin
                        len_d   = cfg_len_i;
                        sum_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (v_i) begin
                        sum_d = add_sum;
                        ovf_d = ovf_q | add_carry;
                        // Counter is cleared on the last sample so it never
                        // exceeds len - 1, even for the maximum frame length.
                        if (cnt_q == len_last) begin
                            cnt_d   = '0;
                            state_d = OUT;
                        end else begin
                            cnt_d = cnt_q + len_width_p'(1);
                        end
                    end
                end
                OUT: begin
                    if (ready_i) begin
                        if (cont_i) begin
                            sum_d   = '0;
                            cnt_d   = '0;
                            ovf_d   = 1'b0;
                            state_d = ACCUM;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // All outputs come straight from registers: no input-to-output paths.
    assign ready_o    = (state_q == ACCUM);
    assign v_o        = (state_q == OUT);
    assign busy_o     = (state_q != IDLE);
    assign sum_o      = sum_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_qcl_accum_frame_ctrl.sv
// Directed testbench for qcl_accum_frame_ctrl. Two instances share the same
// stimulus: a 24-bit-sum instance for the main frame tests and a 16-bit-sum
// instance that exposes wrap-around and the overflow flag.

module tb_qcl_accum_frame_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [7:0]  cfg_len_i;
    logic        start_i;
    logic        cont_i;
    logic        clear_i;
    logic        v_i;
    logic [15:0] data_i;
    logic        ready_i;

    logic        ready_o_a, v_o_a, overflow_o_a, busy_o_a;
    logic [23:0] sum_o_a;
    logic        ready_o_b, v_o_b, overflow_o_b, busy_o_b;
    logic [15:0] sum_o_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    qcl_accum_frame_ctrl #(
        .width_p(16), .sum_width_p(24), .len_width_p(8), .harden_p(0)
    ) dut_a (
        .clk_i(clk_i), .reset_ni(reset_ni), .cfg_len_i(cfg_len_i),
        .start_i(start_i), .cont_i(cont_i), .clear_i(clear_i),
        .v_i(v_i), .data_i(data_i), .ready_o(ready_o_a), .v_o(v_o_a),
        .sum_o(sum_o_a), .overflow_o(overflow_o_a), .ready_i(ready_i),
        .busy_o(busy_o_a)
    );

    qcl_accum_frame_ctrl #(
        .width_p(16), .sum_width_p(16), .len_width_p(8), .harden_p(0)
    ) dut_b (
        .clk_i(clk_i), .reset_ni(reset_ni), .cfg_len_i(cfg_len_i),
        .start_i(start_i), .cont_i(cont_i), .clear_i(clear_i),
        .v_i(v_i), .data_i(data_i), .ready_o(ready_o_b), .v_o(v_o_b),
        .sum_o(sum_o_b), .overflow_o(overflow_o_b), .ready_i(ready_i),
        .busy_o(busy_o_b)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Checks every output of the 24-bit instance.
    task automatic checkState(input string tag, input logic exp_v,
                              input logic exp_ready, input logic exp_busy,
                              input logic [23:0] exp_sum, input logic exp_ovf);
        checkOutput({tag, ".v_o"},        32'(v_o_a),        32'(exp_v));
        checkOutput({tag, ".ready_o"},    32'(ready_o_a),    32'(exp_ready));
        checkOutput({tag, ".busy_o"},     32'(busy_o_a),     32'(exp_busy));
        checkOutput({tag, ".sum_o"},      32'(sum_o_a),      32'(exp_sum));
        checkOutput({tag, ".overflow_o"}, 32'(overflow_o_a), 32'(exp_ovf));
    endtask

    // Drives one cycle of inputs, then waits until just after the rising edge.
    task automatic applyStimulus(input logic start, input logic [7:0] len,
                                 input logic cont, input logic clear,
                                 input logic v, input logic [15:0] data,
                                 input logic rdy);
        start_i   = start;
        cfg_len_i = len;
        cont_i    = cont;
        clear_i   = clear;
        v_i       = v;
        data_i    = data;
        ready_i   = rdy;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [23:0] exp_sum;

        reset_ni  = 1'b0;
        start_i   = 1'b0;
        cfg_len_i = '0;
        cont_i    = 1'b0;
        clear_i   = 1'b0;
        v_i       = 1'b0;
        data_i    = '0;
        ready_i   = 1'b0;

        // Reset state
        #12;
        checkState("reset", 0, 0, 0, 24'd0, 0);
        checkOutput("reset.b_sum", 32'(sum_o_b), 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;

        // Single frame, len 4, samples 1..4 back to back
        applyStimulus(1, 8'd4, 0, 0, 0, 16'd0, 1);
        checkState("f1_start", 0, 1, 1, 24'd0, 0);
        exp_sum = 0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 8'd0, 0, 0, 1, 16'(i), 1);
            exp_sum += 24'(i);
            if (i < 4) checkState($sformatf("f1_acc%0d", i), 0, 1, 1, exp_sum, 0);
        end
        checkState("f1_out", 1, 0, 1, 24'd10, 0);
        applyStimulus(0, 8'd0, 0, 0, 0, 16'd0, 1);
        checkState("f1_idle", 0, 0, 0, 24'd10, 0);

        // Continuous mode, len 2, samples 5,7 then 9,11
        applyStimulus(1, 8'd2, 1, 0, 0, 16'd0, 1);
        applyStimulus(0, 8'd0, 1, 0, 1, 16'd5, 1);
        applyStimulus(0, 8'd0, 1, 0, 1, 16'd7, 1);
        checkState("c_out1", 1, 0, 1, 24'd12, 0);
        applyStimulus(0, 8'd0, 1, 0, 1, 16'd9, 1);
        checkState("c_restart", 0, 1, 1, 24'd0, 0);
        applyStimulus(0, 8'd0, 1, 0, 1, 16'd9, 1);
        checkState("c_acc", 0, 1, 1, 24'd9, 0);
        applyStimulus(0, 8'd0, 1, 0, 1, 16'd11, 1);
        checkState("c_out2", 1, 0, 1, 24'd20, 0);
        applyStimulus(0, 8'd0, 0, 0, 0, 16'd0, 1);
        checkState("c_idle", 0, 0, 0, 24'd20, 0);

        // Back-pressure: consumer stalls 5 cycles while producer keeps v_i high
        applyStimulus(1, 8'd2, 0, 0, 0, 16'd0, 1);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'd3, 1);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'd4, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8'd0, 0, 0, 1, 16'd100, 0);
            checkState($sformatf("bp_hold%0d", i), 1, 0, 1, 24'd7, 0);
        end
        applyStimulus(0, 8'd0, 0, 0, 0, 16'd0, 1);
        checkState("bp_release", 0, 0, 0, 24'd7, 0);
        applyStimulus(0, 8'd0, 0, 0, 0, 16'd0, 1);
        checkState("bp_single", 0, 0, 0, 24'd7, 0);

        // Wrap-around on the 16-bit instance, then a clean follow-on frame
        applyStimulus(1, 8'd2, 0, 0, 0, 16'd0, 1);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'hFFFF, 1);
        applyStimulus(0, 8'd0, 1, 0, 1, 16'h0002, 1);
        checkOutput("ovf.b_v", 32'(v_o_b), 32'd1);
        checkOutput("ovf.b_sum", 32'(sum_o_b), 32'h0001);
        checkOutput("ovf.b_ovf", 32'(overflow_o_b), 32'd1);
        checkState("ovf.a", 1, 0, 1, 24'h010001, 0);
        applyStimulus(0, 8'd0, 1, 0, 0, 16'd0, 1);
        checkOutput("ovf.b_cleared", 32'(overflow_o_b), 32'd0);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'd1, 1);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'd1, 1);
        checkOutput("ovf2.b_v", 32'(v_o_b), 32'd1);
        checkOutput("ovf2.b_sum", 32'(sum_o_b), 32'd2);
        checkOutput("ovf2.b_ovf", 32'(overflow_o_b), 32'd0);
        applyStimulus(0, 8'd0, 0, 0, 0, 16'd0, 1);
        checkOutput("ovf2.b_busy", 32'(busy_o_b), 32'd0);

        // Zero length start is ignored; start mid-frame does not change length
        applyStimulus(1, 8'd0, 0, 0, 0, 16'd0, 1);
        checkState("len0", 0, 0, 0, 24'd2, 0);
        applyStimulus(1, 8'd3, 0, 0, 0, 16'd0, 1);
        applyStimulus(0, 8'd3, 0, 0, 1, 16'd1, 1);
        applyStimulus(1, 8'd1, 0, 0, 1, 16'd2, 1);
        checkState("midstart", 0, 1, 1, 24'd3, 0);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'd3, 1);
        checkState("midstart_out", 1, 0, 1, 24'd6, 0);
        applyStimulus(0, 8'd0, 0, 0, 0, 16'd0, 1);

        // Clear mid-frame beats a simultaneous sample
        applyStimulus(1, 8'd4, 0, 0, 0, 16'd0, 1);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'd1, 1);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'd2, 1);
        checkState("clr_pre", 0, 1, 1, 24'd3, 0);
        applyStimulus(0, 8'd0, 0, 1, 1, 16'd50, 1);
        checkState("clr_acc", 0, 0, 0, 24'd0, 0);
        applyStimulus(1, 8'd1, 0, 0, 0, 16'd0, 1);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'd9, 1);
        checkState("len1_out", 1, 0, 1, 24'd9, 0);
        // Clear beats an output handshake in continuous mode
        applyStimulus(0, 8'd0, 1, 1, 1, 16'd7, 1);
        checkState("clr_out", 0, 0, 0, 24'd0, 0);

        // Asynchronous reset mid-frame drops outputs without a clock edge
        applyStimulus(1, 8'd4, 0, 0, 0, 16'd0, 1);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'd5, 1);
        checkState("rst_pre", 0, 1, 1, 24'd5, 0);
        reset_ni = 1'b0;
        #1;
        checkState("rst_async", 0, 0, 0, 24'd0, 0);
        #2;
        reset_ni = 1'b1;
        applyStimulus(1, 8'd1, 0, 0, 0, 16'd0, 1);
        applyStimulus(0, 8'd0, 0, 0, 1, 16'd2, 1);
        checkState("rst_clean", 1, 0, 1, 24'd2, 0);
        applyStimulus(0, 8'd0, 0, 0, 0, 16'd0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
